// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore sequencer for fetch/decode/execute/memory/writeback,
// per-instruction ALU/extender decode, NZCV flag register and condition-gated write enables.
module arm_mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign unused_rn = ^Instr[7:4];
  assign rd        = Instr[3:0];

  logic next_pc, reg_w, mem_w, branch, alu_op, ir_w;
  logic [1:0] flag_w;
  logic       cond_ex;
  logic       is_add, is_sub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (flag_w[1] && cond_ex) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w[0] && cond_ex) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    next_pc   = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign is_add = (funct[4:1] == 4'b0100);
  assign is_sub = (funct[4:1] == 4'b0010);

  always_comb begin
    ALUControl = 2'b00;
    if (alu_op) begin
      unique case (funct[4:1])
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
    end
  end

  assign flag_w[1] = alu_op & funct[0];
  assign flag_w[0] = alu_op & funct[0] & (is_add | is_sub);

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    unique case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  // Enables are masked by reset directly so an abort kills them in the same cycle.
  logic pcs;
  assign pcs      = branch | (reg_w & (rd == 4'hF));
  assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex));
  assign RegWrite = ~reset & reg_w & cond_ex & (rd != 4'hF);
  assign MemWrite = ~reset & mem_w & cond_ex;
  assign IRWrite  = ~reset & ir_w;

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the ARM datapath: a Moore state machine plus condition-check logic that sequences fetch, decode, execute, memory and writeback over multiple cycles. It drives every datapath enable and mux select, and configures the immediate extender (ImmSrc) and ALU per instruction. It holds the NZCV flags register internally. It sits beside the shared ALU, instruction register and unified memory port.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Instr  in  20  Instr[31:12] from instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  write enables, gated as below
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address
- RegSrc  out  2  [0]=1 for branch (Rn=PC), [1]=1 for memory op (Rm=Rd)
- ALUSrcA  out  2  00=RD1 reg, 01=PC
- ALUSrcB  out  2  00=RD2 reg, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  extender mode
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALU add. Next state is DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALU add (forms PC+8). Next state by op:
  - 01 → MEMADR
  - 00 with funct[5]=0 → EXECR
  - 00 with funct[5]=1 → EXECI
  - 10 → BRANCH
  - 11 → FETCH (undefined, no side effects)
- MEMADR: ALUSrcA=00, ALUSrcB=01, add. Next: funct[0]=1 → MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1. Next: FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Next: ALUWB.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALUOp=1. Next: ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Next: FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1. Next: FETCH.
- Unlisted outputs are 0 in each state.
- ImmSrc = op; RegSrc = {op==01, op==10}.
- ALUControl:
  - ALUOp=0 → 00.
  - ALUOp=1, by funct[4:1]: 0100 → 00, 0010 → 01, 0000 → 10, 1100 → 11, other → 00.
- FlagW, asserted only in EXECR/EXECI:
  - FlagW[1] (NZ) = funct[0].
  - FlagW[0] (CV) = funct[0] & (ADD or SUB).
- CondEx from cond and the stored flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V
  - GT !Z&(N==V), LE Z|(N!=V)
  - 1110 → 1; 1111 → 0
- Gating:
  - PCS = Branch | (RegW & Rd==15)
  - PCWrite = NextPC | (PCS & CondEx)
  - RegWrite = RegW & CondEx & (Rd!=15)
  - MemWrite = MemW & CondEx
- Flags register: the NZ half loads ALUFlags[3:2] when FlagW[1]&CondEx; the CV half loads ALUFlags[1:0] when FlagW[0]&CondEx. A failed-condition instruction still walks its full state sequence but commits nothing.

## Timing
- State and flags update on the rising edge of clk. All outputs are combinational from state, Instr and flags.
- While reset is high:
  - state=FETCH and flags=0000 (asynchronous).
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Mux selects show FETCH values.
- First rising edge after reset deasserts performs FETCH.
- Cycles per instruction: branch 3, data-processing 4, STR 4, LDR 5, undefined op 2.
- Flags written at the end of the EXECR/EXECI cycle are visible to CondEx from the next cycle, i.e. in ALUWB. ALUWB uses the new flags only if the instruction itself set them. The next instruction always sees them.
- Reset asserted mid-instruction aborts it immediately. No write enable is asserted after the reset edge.

## Test plan
- Reset, then release; Instr=0xE2810 (ADD imm, AL):
  - FETCH asserts IRWrite=1 and PCWrite=1.
  - Sequence FETCH→DECODE→EXECI→ALUWB→FETCH.
  - RegWrite=1 only in ALUWB; ImmSrc=00; ALUControl=00 in EXECI.
- SUBS reg (0xE0512):
  - ALUFlags=0100 in EXECR latches Z=1.
  - A following BEQ (0x0A000) asserts PCWrite in BRANCH with ImmSrc=10; BNE (0x1A000) does not.
- LDR (0xE5912):
  - 5-state walk.
  - AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB; ImmSrc=01; RegSrc=10.
- STR with cond NE while Z=1:
  - MemWrite stays 0 for all 4 cycles; state still returns to FETCH.
- ADD with Rd=15, AL:
  - ALUWB asserts PCWrite=1 and RegWrite=0.
- Undefined op=11:
  - FETCH→DECODE→FETCH with no write enables.
  - Reset pulsed during MEMWRITE: MemWrite drops in the same cycle and state is FETCH.
